time_keeper: RTL

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_pkg.sv | 16 +
 rtl/btn_sync_edge.sv | 35 +++
 rtl/time_keeper.sv | 138 +++++++++++++
 3 files changed

// File: rtl/time_pkg.sv
// Shared types and field limits for the time_keeper clock.
package time_pkg;

    localparam int FIELD_W = 6;

    localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;
    localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;
    localparam logic [FIELD_W-1:0] HR_MAX  = 6'd23;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } tk_state_e;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a debounced button followed by a rising-edge
// detector; a held button yields exactly one single-cycle pulse.
module btn_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = btn_raw;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Combinational pulse so a field updates on the 3rd edge after the raw rise.
    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/time_keeper.sv
// 24-hour clock with mode/increment time setting and a free-running
// display scan phase counter.
//
// state      | meaning
// ST_RUN     | time advances on every prescaler tick; inc ignored
// ST_SET_HR  | inc bumps hours (23 -> 0); time frozen
// ST_SET_MIN | inc bumps minutes (59 -> 0, no carry); exit clears seconds
module time_keeper
    import time_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int SCAN_DIV = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [11:0] data_show,
    output logic [2:0]  byte_status,
    output logic [1:0]  set_mode
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    tk_state_e            state_q, state_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic [FIELD_W-1:0]   sec_q, sec_d;
    logic [FIELD_W-1:0]   min_q, min_d;
    logic [FIELD_W-1:0]   hr_q, hr_d;
    logic [SW-1:0]        scan_q, scan_d;
    logic [2:0]           phase_q, phase_d;
    logic                 tick;
    logic                 mode_pulse;
    logic                 inc_pulse;

    btn_sync_edge u_mode_sync (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_mode),
        .pulse   (mode_pulse)
    );

    btn_sync_edge u_inc_sync (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_inc),
        .pulse   (inc_pulse)
    );

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        tick    = 1'b0;

        if (state_q == ST_RUN) begin
            if (pre_q == PW'(TICK_DIV - 1)) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        if (tick) begin
            if (sec_q >= SEC_MAX) begin
                sec_d = '0;
                if (min_q >= MIN_MAX) begin
                    min_d = '0;
                    hr_d  = (hr_q >= HR_MAX) ? '0 : hr_q + 1'b1;
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end

        // Mode wins over a coincident inc; the inc is simply dropped.
        if (mode_pulse) begin
            case (state_q)
                ST_RUN:     state_d = ST_SET_HR;
                ST_SET_HR:  state_d = ST_SET_MIN;
                ST_SET_MIN: begin
                    state_d = ST_RUN;
                    sec_d   = '0;
                    pre_d   = '0;
                end
                default:    state_d = ST_RUN;
            endcase
        end else if (inc_pulse) begin
            case (state_q)
                ST_SET_HR:  hr_d  = (hr_q >= HR_MAX) ? '0 : hr_q + 1'b1;
                ST_SET_MIN: min_d = (min_q >= MIN_MAX) ? '0 : min_q + 1'b1;
                default:    ;
            endcase
        end
    end

    always_comb begin
        scan_d  = scan_q;
        phase_d = phase_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d  = '0;
            phase_d = phase_q + 1'b1;
        end else begin
            scan_d = scan_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pre_q   <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hr_q    <= '0;
            scan_q  <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            scan_q  <= scan_d;
            phase_q <= phase_d;
        end
    end

    assign data_show   = {hr_q, min_q};
    assign byte_status = phase_q;
    assign set_mode    = state_q;

endmodule
